// File: rtl/nn_argmax.sv
// rtl/nn_argmax.sv - sequential argmax over N_CLASS signed scores, lowest index wins ties
// Optional runner-up margin / low-confidence outputs under NN_ARGMAX_MARGIN_EN.
module nn_argmax #(
  parameter int N_CLASS   = 10,
  parameter int SCORE_W   = 8,
  parameter int IDX_W     = 4,
  parameter int MARGIN_TH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CLASS*SCORE_W-1:0] scores,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           class_idx,
  output logic [SCORE_W-1:0]         max_score,
  output logic                       busy
`ifdef NN_ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W:0]           margin,
  output logic                       low_conf
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASS - 1);
  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t state_q, state_d;
  logic signed [SCORE_W-1:0] vec_q [N_CLASS];
  logic signed [SCORE_W-1:0] vec_d [N_CLASS];
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic signed [SCORE_W-1:0] cur;
  // Result registers are separate from the scan registers so outputs hold during SCAN.
  logic [IDX_W-1:0]          cls_q, cls_d;
  logic [SCORE_W-1:0]        max_q, max_d;
`ifdef NN_ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] second_q, second_d;
  logic [SCORE_W:0]          margin_q, margin_d;
  logic                      lowc_q, lowc_d;
`endif

  assign cur = vec_q[cnt_q];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    best_d  = best_q;
    cls_d   = cls_q;
    max_d   = max_q;
`ifdef NN_ARGMAX_MARGIN_EN
    second_d = second_q;
    margin_d = margin_q;
    lowc_d   = lowc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N_CLASS; k++) vec_d[k] = scores[k*SCORE_W +: SCORE_W];
          best_d  = scores[SCORE_W-1:0];
          idx_d   = '0;
          cnt_d   = IDX_W'(1);
          state_d = SCAN;
`ifdef NN_ARGMAX_MARGIN_EN
          second_d = MOST_NEG;
`endif
        end
      end
      SCAN: begin
        if (cur > best_q) begin
          best_d = cur;
          idx_d  = cnt_q;
`ifdef NN_ARGMAX_MARGIN_EN
          second_d = best_q;
        end else if (cur > second_q) begin
          second_d = cur;
`endif
        end
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cls_d   = idx_d;
          max_d   = best_d;
`ifdef NN_ARGMAX_MARGIN_EN
          margin_d = {best_d[SCORE_W-1], best_d} - {second_d[SCORE_W-1], second_d};
          lowc_d   = (margin_d < (SCORE_W+1)'(MARGIN_TH));
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      cls_q   <= '0;
      max_q   <= '0;
`ifdef NN_ARGMAX_MARGIN_EN
      second_q <= '0;
      margin_q <= '0;
      lowc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      cls_q   <= cls_d;
      max_q   <= max_d;
`ifdef NN_ARGMAX_MARGIN_EN
      second_q <= second_d;
      margin_q <= margin_d;
      lowc_q   <= lowc_d;
`endif
    end
  end

  // The captured vector needs no reset; it is always written before being scanned.
  always_ff @(posedge clk) begin
    vec_q <= vec_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign class_idx = cls_q;
  assign max_score = max_q;
`ifdef NN_ARGMAX_MARGIN_EN
  assign margin    = margin_q;
  assign low_conf  = lowc_q;
`endif

endmodule

// File: tb/tb_nn_argmax.sv
// tb/tb_nn_argmax.sv - randomized and directed self-checking bench for nn_argmax
// Reference model: plain-array argmax and runner-up over the score vector.
module tb_nn_argmax;
  localparam int N = 10;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] scores;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     class_idx;
  logic [W-1:0]   max_score;
  logic           busy;
`ifdef NN_ARGMAX_MARGIN_EN
  logic [W:0]     margin;
  logic           low_conf;
`endif

  int checks = 0;
  int errors = 0;

  nn_argmax dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
    .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
    .max_score(max_score), .busy(busy)
`ifdef NN_ARGMAX_MARGIN_EN
    , .margin(margin), .low_conf(low_conf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [N*W-1:0] s, output int ei, output int em, output int eg);
    int v[N];
    int sec;
    for (int k = 0; k < N; k++) v[k] = int'($signed(s[k*W +: W]));
    ei = 0;
    for (int k = 1; k < N; k++) if (v[k] > v[ei]) ei = k;
    em = v[ei];
    sec = -128;
    for (int k = 0; k < N; k++) if (k != ei && v[k] > sec) sec = v[k];
    eg = em - sec;
  endfunction

  function automatic logic [N*W-1:0] pack(input int a[N]);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(a[k]);
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    int a[N];
    bit narrow;
    narrow = $urandom_range(0, 1) == 1;
    for (int k = 0; k < N; k++)
      a[k] = narrow ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 255)) - 128;
    return pack(a);
  endfunction

  task automatic check_result(input string tag, input int ei, input int em, input int eg);
    check({tag, "_idx"}, int'(class_idx), ei);
    check({tag, "_max"}, int'($signed(max_score)), em);
`ifdef NN_ARGMAX_MARGIN_EN
    check({tag, "_margin"}, int'(margin), eg);
    check({tag, "_lowc"}, int'(low_conf), (eg < 8) ? 1 : 0);
`endif
  endtask

  // Offer the current vector, check latency and result, hold DONE for `hold` cycles, then accept.
  task automatic run_vec(input string tag, input int hold);
    int ei, em, eg, n;
    model(scores, ei, em, eg);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_accept_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scores = rand_vec();
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, n, 9);
    check_result(tag, ei, em, eg);
    in_valid = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_inready"}, int'(in_ready), 0);
      check({tag, "_hold_idx"}, int'(class_idx), ei);
      check({tag, "_hold_max"}, int'($signed(max_score)), em);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, int'(out_valid), 0);
    check({tag, "_post_inready"}, int'(in_ready), 1);
    check({tag, "_post_busy"}, int'(busy), 0);
  endtask

  initial begin
    int d[N];
    int ei, em, eg, n, seen, last_cyc;
    int exp_q[$];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; scores = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inready", int'(in_ready), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_idx", int'(class_idx), 0);
    check("rst_max", int'(max_score), 0);
    check("rst_busy", int'(busy), 0);
`ifdef NN_ARGMAX_MARGIN_EN
    check("rst_margin", int'(margin), 0);
    check("rst_lowc", int'(low_conf), 0);
`endif
    rst = 1'b0;
    #1;
    check("rel_inready", int'(in_ready), 1);

    d = '{3, -5, 20, 7, 20, -128, 0, 19, 1, 2};
    scores = pack(d);
    run_vec("tie", 0);
    for (int k = 0; k < N; k++) d[k] = -128;
    scores = pack(d);
    run_vec("allneg", 0);
    for (int k = 0; k < N; k++) d[k] = -1;
    d[9] = 127;
    scores = pack(d);
    run_vec("last", 20);

    scores = rand_vec();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_idx", int'(class_idx), 0);
    check("abort_max", int'(max_score), 0);
    check("abort_busy", int'(busy), 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", seen, 0);

    for (int i = 0; i < 4; i++) begin
      scores = rand_vec();
      run_vec("rand", int'($urandom_range(0, 3)));
    end

    // Back-to-back with out_ready tied high; scores change every cycle.
    out_ready = 1'b1;
    in_valid = 1'b1;
    last_cyc = -1;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      scores = rand_vec();
      if (out_valid) begin
        if (exp_q.size() >= 3) begin
          em = exp_q.pop_front(); ei = exp_q.pop_front(); eg = exp_q.pop_front();
          check_result("b2b", ei, em, eg);
        end else check("b2b_queue", exp_q.size(), 3);
        if (last_cyc >= 0) check("b2b_period", c - last_cyc, 11);
        last_cyc = c;
        seen++;
      end
      if (in_ready) begin
        model(scores, ei, em, eg);
        exp_q.push_back(em); exp_q.push_back(ei); exp_q.push_back(eg);
      end
      @(posedge clk); #1;
    end
    check("b2b_count_ok", (seen >= 6) ? 1 : 0, 1);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
